multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and writeback over a shared ALU, register file and memory ports.
- Drives the immediate-format select consumed by the immediate generator, plus ALU, PC, register-file and memory strobes.
- Performs the instruction-memory and data-memory request/ready handshakes.

Parameters:
- WIDTH, 32, datapath width; sets the instret counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instr[6:0], taken from the registered IR
- branch_taken  input  1  branch-comparator result, valid in EXEC
- imem_ready  input  1  instruction memory data valid
- dmem_ready  input  1  data memory access complete
- imem_req  output  1  instruction fetch request
- ir_we  output  1  load IR
- imm_sel  output  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J
- alu_src_a  output  2  0=rs1, 1=pc, 2=zero
- alu_src_b  output  1  0=rs2, 1=imm
- alu_op  output  2  0=add, 1=sub, 2=funct-decoded, 3=pass B
- mem_req  output  1  data memory request
- mem_we  output  1  data memory write
- reg_we  output  1  register file write
- wb_sel  output  2  0=ALU, 1=load data, 2=pc+4
- pc_we  output  1  PC update; exactly one pulse per retired instruction
- pc_src  output  2  0=pc+4, 1=pc+imm, 2=ALU result with bit 0 cleared
- halted  output  1  FSM in HALT
- illegal  output  1  halt was caused by an unknown opcode
- instret  output  WIDTH  retired-instruction count

Behaviour:
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. The state register resets asynchronously to FETCH.
- Outputs are combinational from state and opcode. Any strobe not listed for a state is 0.
- Reset: while rst_n=0, imem_req=1 and every other strobe is 0; halted=0, illegal=0, instret=0. Reset asserted mid-instruction aborts it: mem_req and pc_we drop immediately and nothing retires.
- FETCH: imem_req=1 until imem_ready is sampled high; the request is never withdrawn early. In the ready cycle, ir_we=1 and next state is DECODE. imem_ready outside FETCH is ignored.
- DECODE (1 cycle):
  - Supported opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Supported opcode -> EXEC.
  - SYSTEM 1110011 -> HALT with illegal=0.
  - Any other opcode -> HALT with illegal=1.
- imm_sel:
  - Per opcode: I for OP-IMM/LOAD/JALR, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL, 0 otherwise.
  - Valid in DECODE through the last state of the instruction; 0 in FETCH.
- EXEC settings per opcode:
  - OP: a=rs1, b=rs2, op=2.
  - OP-IMM: a=rs1, b=imm, op=2.
  - LOAD/STORE/JALR: a=rs1, b=imm, op=0.
  - AUIPC: a=pc, b=imm, op=0.
  - LUI: b=imm, op=3.
  - BRANCH: a=rs1, b=rs2, op=1.
- EXEC transitions:
  - LOAD/STORE -> MEM.
  - BRANCH: pc_we=1, pc_src = branch_taken ? 1 : 0, then -> FETCH.
  - All other supported opcodes -> WB.
- MEM:
  - mem_req=1 and mem_we=(STORE); ALU controls are held at their EXEC values. Wait for dmem_ready.
  - On dmem_ready, LOAD -> WB.
  - On dmem_ready, STORE: pc_we=1, pc_src=0, then -> FETCH.
  - dmem_ready outside MEM is ignored.
- WB:
  - reg_we=1, pc_we=1, then -> FETCH. ALU controls are held at their EXEC values.
  - wb_sel = 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_src = 1 for JAL, 2 for JALR, 0 otherwise.
- HALT: all strobes 0, halted=1; illegal is held. Only reset exits HALT.
- Latency with zero-wait memories (ready high on the first request cycle):
  - BRANCH: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.

Optional Feature:
- Macro: INSTRET_EN.
- Defined: instret is a WIDTH-bit register, async-reset to 0, incremented on each clock edge where pc_we=1. It wraps from all-ones to 0 and freezes in HALT.
- Undefined: the instret port remains and is tied to 0; no counter logic is instantiated.

Test Plan:
- Reset, then OP (opcode 0110011), imem_ready held high: states 0,1,2,4,0; reg_we=1 and pc_we=1 with pc_src=0 in the WB cycle only; instret=1 with INSTRET_EN.
- LOAD with dmem_ready low for 3 MEM cycles: mem_req=1 and mem_we=0 held for 4 cycles; imm_sel=0 (I); WB gives wb_sel=1; total 8 cycles.
- BRANCH with branch_taken=1, then BRANCH with branch_taken=0: imm_sel=2, alu_op=1; the EXEC pulse gives pc_src=1, then pc_src=0; 3 cycles each; reg_we never asserted.
- JAL, then JALR: imm_sel=4 with wb_sel=2, pc_src=1; then imm_sel=0 with wb_sel=2, pc_src=2.
- Opcode 1111111: HALT after DECODE with halted=1, illegal=1; imem_ready toggling causes no strobes; rst_n low clears both flags and imem_req=1.
- STORE in MEM with dmem_ready low, rst_n pulsed low: mem_req drops asynchronously, state=FETCH, instret unchanged at 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM of the multi-cycle RV32I core. It sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH over a shared ALU,
// register file and memory ports. It also performs the instruction- and
// data-memory request/ready handshakes. Unknown opcodes and SYSTEM park
// the FSM in HALT, which only reset leaves.
//
// Optional feature (macro INSTRET_EN):
//   defined   - instret counts every clock edge with pc_we=1 (wraps, frozen
//               in HALT because pc_we is 0 there)
//   undefined - instret is tied to 0 and no counter is built
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   opcode       instr[6:0] from the registered IR
//   branch_taken branch-comparator result, used in EXEC
//   imem_ready   instruction memory data valid (FETCH only)
//   dmem_ready   data memory access complete (MEM only)
//   imem_req     instruction fetch request
//   ir_we        load IR
//   imm_sel      immediate format 0=I 1=S 2=B 3=U 4=J
//   alu_src_a    0=rs1 1=pc 2=zero
//   alu_src_b    0=rs2 1=imm
//   alu_op       0=add 1=sub 2=funct-decoded 3=pass B
//   mem_req      data memory request
//   mem_we       data memory write
//   reg_we       register file write
//   wb_sel       0=ALU 1=load data 2=pc+4
//   pc_we        PC update, one pulse per retired instruction
//   pc_src       0=pc+4 1=pc+imm 2=ALU result with bit 0 cleared
//   halted       FSM is in HALT
//   illegal      HALT was caused by an unknown opcode
//   instret      retired-instruction count (WIDTH bits)
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic [2:0]       imm_sel,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_req,
  output logic             mem_we,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             illegal,
  output logic [WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  state_t     state, state_nxt;
  logic       illegal_q;
  logic       illegal_set;

  // Opcode decode: per-instruction immediate format and ALU setup
  logic       supported;
  logic [2:0] imm_dec;
  logic [1:0] a_dec;
  logic       b_dec;
  logic [1:0] op_dec;

  always_comb begin
    supported = 1'b1;
    imm_dec   = IMM_I;
    a_dec     = 2'd0;
    b_dec     = 1'b0;
    op_dec    = 2'd0;
    case (opcode)
      OPC_OP:     op_dec = 2'd2;
      OPC_OPIMM:  begin b_dec = 1'b1; op_dec = 2'd2; end
      OPC_LOAD,
      OPC_JALR:   b_dec = 1'b1;
      OPC_STORE:  begin imm_dec = IMM_S; b_dec = 1'b1; end
      OPC_AUIPC:  begin imm_dec = IMM_U; a_dec = 2'd1; b_dec = 1'b1; end
      OPC_LUI:    begin imm_dec = IMM_U; b_dec = 1'b1; op_dec = 2'd3; end
      OPC_BRANCH: begin imm_dec = IMM_B; op_dec = 2'd1; end
      OPC_JAL:    imm_dec = IMM_J;
      default:    supported = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    illegal_set = 1'b0;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    imm_sel     = IMM_I;
    alu_src_a   = 2'd0;
    alu_src_b   = 1'b0;
    alu_op      = 2'd0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'd0;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          // Reset forces FETCH, but the IR must not load while held in reset
          ir_we     = rst_n;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        imm_sel = imm_dec;
        if (supported) begin
          state_nxt = EXEC;
        end else begin
          state_nxt   = HALT;
          illegal_set = (opcode != OPC_SYSTEM);
        end
      end
      EXEC: begin
        imm_sel   = imm_dec;
        alu_src_a = a_dec;
        alu_src_b = b_dec;
        alu_op    = op_dec;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_nxt = MEM;
          OPC_BRANCH: begin
            pc_we     = 1'b1;
            pc_src    = branch_taken ? 2'd1 : 2'd0;
            state_nxt = FETCH;
          end
          default: state_nxt = WB;
        endcase
      end
      MEM: begin
        imm_sel   = imm_dec;
        alu_src_a = a_dec;
        alu_src_b = b_dec;
        alu_op    = op_dec;
        mem_req   = 1'b1;
        mem_we    = (opcode == OPC_STORE);
        if (dmem_ready) begin
          if (opcode == OPC_STORE) begin
            pc_we     = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        imm_sel   = imm_dec;
        alu_src_a = a_dec;
        alu_src_b = b_dec;
        alu_op    = op_dec;
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        case (opcode)
          OPC_LOAD: wb_sel = 2'd1;
          OPC_JAL:  begin wb_sel = 2'd2; pc_src = 2'd1; end
          OPC_JALR: begin wb_sel = 2'd2; pc_src = 2'd2; end
          default:  ;
        endcase
        state_nxt = FETCH;
      end
      HALT: halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  assign illegal = illegal_q;

`ifdef INSTRET_EN
  logic [WIDTH-1:0] instret_q;

  // pc_we is never asserted in HALT, so the count freezes there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     instret_q <= '0;
    else if (pc_we) instret_q <= instret_q + 1'b1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int WIDTH = 32;
`ifdef INSTRET_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_BAD    = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_we;
  logic [2:0]       imm_sel;
  logic [1:0]       alu_src_a;
  logic             alu_src_b;
  logic [1:0]       alu_op;
  logic             mem_req;
  logic             mem_we;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             halted;
  logic             illegal;
  logic [WIDTH-1:0] instret;

  multicycle_controller #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_we(ir_we), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_req(mem_req),
    .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_src(pc_src), .halted(halted), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {imem_req, ir_we, imm_sel, alu_src_a, alu_src_b, alu_op,
                mem_req, mem_we, reg_we, wb_sel, pc_we, pc_src, halted, illegal};

  logic [19:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_ret  = 0;

  // Expected strobe vector, fields in port order
  function automatic logic [19:0] e(
    input logic ireq, input logic iwe, input logic [2:0] imm,
    input logic [1:0] a, input logic b, input logic [1:0] op,
    input logic mr, input logic mw, input logic rw, input logic [1:0] wb,
    input logic pw, input logic [1:0] ps, input logic h, input logic il);
    return {ireq, iwe, imm, a, b, op, mr, mw, rw, wb, pw, ps, h, il};
  endfunction

  function automatic logic [19:0] fetch_rdy();
    return e(1,1,0, 0,0,0, 0,0,0,0, 0,0, 0,0);
  endfunction

  function automatic logic [19:0] rst_vec();
    return e(1,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0);
  endfunction

  task automatic push(input string t, input logic [19:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk_vec();
    logic [19:0] ev;
    string       t;
    n_checks++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
    end
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      t  = tag_q.pop_front();
      n_checks++;
      assert (obs === ev) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", t, obs, ev);
      end
    end
  endtask

  task automatic chk_ret(input string t);
    logic [WIDTH-1:0] ev;
    ev = RET_EN ? WIDTH'(exp_ret) : '0;
    n_checks++;
    assert (instret === ev) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", t, instret, ev);
    end
  endtask

  // One clock: drive inputs after the active edge, sample on the falling edge
  task automatic cyc(input logic ir, input logic dr, input logic bt);
    imem_ready   = ir;
    dmem_ready   = dr;
    branch_taken = bt;
    @(negedge clk);
    chk_vec();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string t);
    imem_ready = 1'b1;
    rst_n      = 1'b0;
    #1;
    push(t, rst_vec());
    chk_vec();
    exp_ret = 0;
    chk_ret({t, "_instret"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = OPC_OP; branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #2;
    push("reset_outputs", rst_vec());
    chk_vec();
    repeat (2) @(posedge clk);
    #1;
    push("reset_held_ready", rst_vec());
    chk_vec();
    chk_ret("reset_instret");
    rst_n = 1'b1;

    // OP, zero-wait
    opcode = OPC_OP;
    push("op_fetch",  fetch_rdy());
    push("op_decode", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("op_exec",   e(0,0,0, 0,0,2, 0,0,0,0, 0,0, 0,0));
    push("op_wb",     e(0,0,0, 0,0,2, 0,0,1,0, 1,0, 0,0));
    repeat (4) cyc(1, 0, 0);
    exp_ret++;
    chk_ret("op_instret");

    // LOAD with three memory wait cycles; dmem_ready high before MEM is ignored
    opcode = OPC_LOAD;
    push("ld_fetch",  fetch_rdy());
    push("ld_decode", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("ld_exec",   e(0,0,0, 0,1,0, 0,0,0,0, 0,0, 0,0));
    for (int i = 0; i < 4; i++) push("ld_mem", e(0,0,0, 0,1,0, 1,0,0,0, 0,0, 0,0));
    push("ld_wb",     e(0,0,0, 0,1,0, 0,0,1,1, 1,0, 0,0));
    repeat (3) cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    exp_ret++;
    chk_ret("ld_instret");

    // BRANCH taken, then not taken
    opcode = OPC_BRANCH;
    push("bt_fetch",  fetch_rdy());
    push("bt_decode", e(0,0,2, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("bt_exec",   e(0,0,2, 0,0,1, 0,0,0,0, 1,1, 0,0));
    repeat (3) cyc(1, 0, 1);
    push("bn_fetch",  fetch_rdy());
    push("bn_decode", e(0,0,2, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("bn_exec",   e(0,0,2, 0,0,1, 0,0,0,0, 1,0, 0,0));
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    exp_ret += 2;
    chk_ret("br_instret");

    // JAL then JALR
    opcode = OPC_JAL;
    push("jal_fetch",  fetch_rdy());
    push("jal_decode", e(0,0,4, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("jal_exec",   e(0,0,4, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("jal_wb",     e(0,0,4, 0,0,0, 0,0,1,2, 1,1, 0,0));
    repeat (4) cyc(1, 0, 0);
    opcode = OPC_JALR;
    push("jalr_fetch",  fetch_rdy());
    push("jalr_decode", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("jalr_exec",   e(0,0,0, 0,1,0, 0,0,0,0, 0,0, 0,0));
    push("jalr_wb",     e(0,0,0, 0,1,0, 0,0,1,2, 1,2, 0,0));
    repeat (4) cyc(1, 0, 0);
    exp_ret += 2;

    // LUI, AUIPC, OP-IMM
    opcode = OPC_LUI;
    push("lui_fetch",  fetch_rdy());
    push("lui_decode", e(0,0,3, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("lui_exec",   e(0,0,3, 0,1,3, 0,0,0,0, 0,0, 0,0));
    push("lui_wb",     e(0,0,3, 0,1,3, 0,0,1,0, 1,0, 0,0));
    repeat (4) cyc(1, 0, 0);
    opcode = OPC_AUIPC;
    push("auipc_fetch",  fetch_rdy());
    push("auipc_decode", e(0,0,3, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("auipc_exec",   e(0,0,3, 1,1,0, 0,0,0,0, 0,0, 0,0));
    push("auipc_wb",     e(0,0,3, 1,1,0, 0,0,1,0, 1,0, 0,0));
    repeat (4) cyc(1, 0, 0);
    opcode = OPC_OPIMM;
    push("opimm_fetch",  fetch_rdy());
    push("opimm_decode", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("opimm_exec",   e(0,0,0, 0,1,2, 0,0,0,0, 0,0, 0,0));
    push("opimm_wb",     e(0,0,0, 0,1,2, 0,0,1,0, 1,0, 0,0));
    repeat (4) cyc(1, 0, 0);
    exp_ret += 3;

    // STORE, zero-wait memory
    opcode = OPC_STORE;
    push("st_fetch",  fetch_rdy());
    push("st_decode", e(0,0,1, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("st_exec",   e(0,0,1, 0,1,0, 0,0,0,0, 0,0, 0,0));
    push("st_mem",    e(0,0,1, 0,1,0, 1,1,0,0, 1,0, 0,0));
    repeat (4) cyc(1, 1, 0);
    exp_ret++;
    chk_ret("mix_instret");

    // Fetch wait states, then SYSTEM halts without illegal
    opcode = OPC_SYSTEM;
    push("fw_wait0",  rst_vec());
    push("fw_wait1",  rst_vec());
    push("sys_fetch", fetch_rdy());
    push("sys_decode", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("sys_halt0", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 1,0));
    push("sys_halt1", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 1,0));
    cyc(0, 0, 0);
    cyc(0, 1, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    cyc(0, 1, 0);
    chk_ret("sys_instret_frozen");
    apply_reset("sys_reset");

    // Unknown opcode: HALT with illegal, held while inputs toggle
    opcode = OPC_BAD;
    push("bad_fetch",  fetch_rdy());
    push("bad_decode", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0));
    for (int i = 0; i < 3; i++) push("bad_halt", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 1,1));
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    opcode = OPC_OP;
    cyc(1, 1, 0);
    cyc(0, 1, 1);
    apply_reset("bad_reset");

    // STORE aborted by reset while waiting in MEM
    opcode = OPC_STORE;
    push("sta_fetch",  fetch_rdy());
    push("sta_decode", e(0,0,1, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("sta_exec",   e(0,0,1, 0,1,0, 0,0,0,0, 0,0, 0,0));
    push("sta_mem",    e(0,0,1, 0,1,0, 1,1,0,0, 0,0, 0,0));
    repeat (3) cyc(1, 0, 0);
    cyc(1, 0, 0);
    apply_reset("sta_abort");

    // Recovery after abort
    opcode = OPC_OP;
    push("rec_fetch",  fetch_rdy());
    push("rec_decode", e(0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0));
    push("rec_exec",   e(0,0,0, 0,0,2, 0,0,0,0, 0,0, 0,0));
    push("rec_wb",     e(0,0,0, 0,0,2, 0,0,1,0, 1,0, 0,0));
    repeat (4) cyc(1, 0, 0);
    exp_ret++;
    chk_ret("rec_instret");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
